// File: rtl/alu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared types and constants for the registered ALU-control decoder.
//   aluop_e      : op class from main control (R/BR/LDST/I/UPPER)
//   ctrl_class_e : top two bits of the ALU control word (INT/CMP/MULDIV)
//   ALU_*        : 6-bit ALU control words {class[1:0], alt, funct3}
//   state_e      : stall FSM states
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        ALUOP_R     = 3'b000,
        ALUOP_BR    = 3'b001,
        ALUOP_LDST  = 3'b010,
        ALUOP_I     = 3'b011,
        ALUOP_UPPER = 3'b100
    } aluop_e;

    typedef enum logic [1:0] {
        CLASS_INT    = 2'b00,
        CLASS_CMP    = 2'b01,
        CLASS_MULDIV = 2'b10
    } ctrl_class_e;

    localparam logic [5:0] ALU_ADD  = 6'b00_0_000;
    localparam logic [5:0] ALU_SUB  = 6'b00_1_000;
    localparam logic [5:0] ALU_SLL  = 6'b00_0_001;
    localparam logic [5:0] ALU_SLT  = 6'b00_0_010;
    localparam logic [5:0] ALU_SLTU = 6'b00_0_011;
    localparam logic [5:0] ALU_XOR  = 6'b00_0_100;
    localparam logic [5:0] ALU_SRL  = 6'b00_0_101;
    localparam logic [5:0] ALU_SRA  = 6'b00_1_101;
    localparam logic [5:0] ALU_OR   = 6'b00_0_110;
    localparam logic [5:0] ALU_AND  = 6'b00_0_111;

    typedef enum logic {
        IDLE    = 1'b0,
        MD_WAIT = 1'b1
    } state_e;

    function automatic logic [5:0] pack_ctrl(input ctrl_class_e cls, input logic alt,
                                             input logic [2:0] f3);
        return {cls, alt, f3};
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// -----------------------------------------------------------------------------
// alu_ctrl_decode
// Pure combinational decode of ALUOp + {funct7[0], funct7[5], funct3} into the
// 6-bit ALU control word, an illegal flag and MUL/DIV classification.
// RV32M decode is present only when ALU_CTRL_MEXT_EN is defined.
// Ports:
//   i_aluop       in  3  op class from main control
//   i_bits        in  5  {funct7[0], funct7[5], funct3}
//   o_alu_control out 6  {class, alt, funct3}; ADD whenever illegal
//   o_illegal     out 1  encoding is not legal
//   o_is_muldiv   out 1  legal RV32M op (needs a muldiv stall)
//   o_is_div      out 1  funct3[2]: DIV*/REM* rather than MUL*
// -----------------------------------------------------------------------------
module alu_ctrl_decode (
    input  logic [2:0] i_aluop,
    input  logic [4:0] i_bits,
    output logic [5:0] o_alu_control,
    output logic       o_illegal,
    output logic       o_is_muldiv,
    output logic       o_is_div
);
    import alu_ctrl_pkg::*;

    logic       w_f7b0;
    logic       w_f7b5;
    logic [2:0] w_f3;
    logic [5:0] w_ctrl;
    logic       w_ill;
    logic       w_md;

    assign w_f7b0 = i_bits[4];
    assign w_f7b5 = i_bits[3];
    assign w_f3   = i_bits[2:0];

    always_comb begin
        w_ctrl = ALU_ADD;
        w_ill  = 1'b0;
        w_md   = 1'b0;
        case (i_aluop)
            ALUOP_R: begin
                if (w_f7b0) begin
`ifdef ALU_CTRL_MEXT_EN
                    if (w_f7b5) begin
                        w_ill = 1'b1;
                    end else begin
                        w_ctrl = pack_ctrl(CLASS_MULDIV, 1'b0, w_f3);
                        w_md   = 1'b1;
                    end
`else
                    w_ill = 1'b1;
`endif
                end else if (w_f7b5 && (w_f3 != 3'b000) && (w_f3 != 3'b101)) begin
                    // Only SUB and SRA use funct7[5]; no aliasing onto other ops.
                    w_ill = 1'b1;
                end else begin
                    w_ctrl = pack_ctrl(CLASS_INT, w_f7b5, w_f3);
                end
            end
            ALUOP_BR: begin
                if ((w_f3 == 3'b010) || (w_f3 == 3'b011)) begin
                    w_ill = 1'b1;
                end else begin
                    w_ctrl = pack_ctrl(CLASS_CMP, 1'b0, w_f3);
                end
            end
            ALUOP_LDST, ALUOP_UPPER: begin
                w_ctrl = ALU_ADD;
            end
            ALUOP_I: begin
                if ((w_f3 == 3'b001) && w_f7b5) begin
                    w_ill = 1'b1;
                end else begin
                    // funct7[5] of an immediate is data except for SRAI.
                    w_ctrl = pack_ctrl(CLASS_INT, (w_f3 == 3'b101) ? w_f7b5 : 1'b0, w_f3);
                end
            end
            default: begin
                w_ill = 1'b1;
            end
        endcase
        if (w_ill) begin
            w_ctrl = ALU_ADD;
            w_md   = 1'b0;
        end
    end

    assign o_alu_control = w_ctrl;
    assign o_illegal     = w_ill;
    assign o_is_muldiv   = w_md;
    assign o_is_div      = w_f3[2];

endmodule

// File: rtl/alu_control_seq.sv
// -----------------------------------------------------------------------------
// alu_control_seq
// Registered, valid/ready handshaked ALU-control decoder. An accepted op shows
// on the outputs one cycle later with a single-cycle out_valid pulse. Legal
// MUL/DIV ops hold off new input while the muldiv unit works.
// Optional feature: ALU_CTRL_MEXT_EN enables RV32M decode and the stall FSM;
// without it, in_ready is tied high and md_busy tied low.
// Ports:
//   CLK, RST_n        clock (rising), async active-low reset
//   in_valid/in_ready input handshake
//   flush             sync kill of output register and any stall
//   ALUOp, instruction_bits  op class and {funct7[0], funct7[5], funct3}
//   out_valid, ALU_control, illegal  registered decode result
//   md_busy           MUL/DIV stall in progress
// -----------------------------------------------------------------------------
module alu_control_seq #(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DIV_LAT = 33
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       flush,
    input  logic [2:0] ALUOp,
    input  logic [4:0] instruction_bits,
    output logic       out_valid,
    output logic [5:0] ALU_control,
    output logic       illegal,
    output logic       md_busy
);
    import alu_ctrl_pkg::*;

    logic [5:0] w_ctrl;
    logic       w_illegal;
    logic       w_is_muldiv;
    logic       w_is_div;
    logic       w_in_ready;
    logic       w_accept;

    logic       r_out_valid;
    logic [5:0] r_ctrl;
    logic       r_illegal;

    alu_ctrl_decode u_decode (
        .i_aluop       (ALUOp),
        .i_bits        (instruction_bits),
        .o_alu_control (w_ctrl),
        .o_illegal     (w_illegal),
        .o_is_muldiv   (w_is_muldiv),
        .o_is_div      (w_is_div)
    );

    // flush wins over a transfer in the same cycle.
    assign w_accept = in_valid & w_in_ready & ~flush;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_out_valid <= 1'b0;
            r_ctrl      <= ALU_ADD;
            r_illegal   <= 1'b0;
        end else begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_ctrl    <= w_ctrl;
                r_illegal <= w_illegal;
            end
        end
    end

`ifdef ALU_CTRL_MEXT_EN
    localparam int unsigned MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    state_e             r_state;
    state_e             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [CNT_W-1:0]   w_cnt_load;

    // Stall cycles = latency - 1; a latency of 1 loads 0 and never stalls.
    assign w_cnt_load = w_is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (flush) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && w_is_muldiv && (w_cnt_load != '0)) begin
                        w_state_next = MD_WAIT;
                        w_cnt_next   = w_cnt_load;
                    end
                end
                MD_WAIT: begin
                    // Leave on the cycle the count would reach zero.
                    if (r_cnt <= CNT_W'(1)) begin
                        w_state_next = IDLE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    assign w_in_ready = (r_state == IDLE);
    assign md_busy    = (r_state == MD_WAIT);
`else
    localparam int unsigned unused_lat = MUL_LAT + DIV_LAT;
    logic w_unused_md;

    assign w_unused_md = w_is_muldiv ^ w_is_div;
    assign w_in_ready  = 1'b1;
    assign md_busy     = 1'b0;
`endif

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign ALU_control = r_ctrl;
    assign illegal     = r_illegal;

endmodule

// File: tb/tb_alu_control_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_control_seq
// Directed bench for alu_control_seq (default MUL_LAT=3, DIV_LAT=33).
// Works with or without ALU_CTRL_MEXT_EN defined.
// -----------------------------------------------------------------------------
module tb_alu_control_seq;

    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned DIV_LAT = 33;
`ifdef ALU_CTRL_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] ALUOp = 3'b000;
    logic [4:0] instruction_bits = 5'b00000;
    logic       in_ready;
    logic       out_valid;
    logic [5:0] ALU_control;
    logic       illegal;
    logic       md_busy;

    int n_checks = 0;
    int n_errors = 0;

    alu_control_seq #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .CLK              (CLK),
        .RST_n            (RST_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .flush            (flush),
        .ALUOp            (ALUOp),
        .instruction_bits (instruction_bits),
        .out_valid        (out_valid),
        .ALU_control      (ALU_control),
        .illegal          (illegal),
        .md_busy          (md_busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode: returns {illegal, ctrl[5:0]}.
    function automatic logic [6:0] model(input logic [2:0] op, input logic [4:0] b);
        logic f7b0, f7b5;
        logic [2:0] f3;
        f7b0 = b[4];
        f7b5 = b[3];
        f3   = b[2:0];
        case (op)
            3'd0: begin
                if (f7b0) begin
                    if (MEXT && !f7b5) return {1'b0, 2'b10, 1'b0, f3};
                    return 7'b1_000000;
                end
                if (f7b5 && f3 != 3'b000 && f3 != 3'b101) return 7'b1_000000;
                return {1'b0, 2'b00, f7b5, f3};
            end
            3'd1: begin
                if (f3 == 3'b010 || f3 == 3'b011) return 7'b1_000000;
                return {1'b0, 2'b01, 1'b0, f3};
            end
            3'd2, 3'd4: return 7'b0_000000;
            3'd3: begin
                if (f3 == 3'b001 && f7b5) return 7'b1_000000;
                return {1'b0, 2'b00, (f3 == 3'b101) ? f7b5 : 1'b0, f3};
            end
            default: return 7'b1_000000;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [4:0] b);
        ALUOp = op;
        instruction_bits = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [6:0] exp;
        int k;
        int low_cnt;
        int busy_cnt;
        int vld_cnt;
        logic [2:0] dir_op [6];
        logic [4:0] dir_bits [6];
        logic [6:0] dir_exp [6];

        // Hand-computed directed vectors: {illegal, ctrl}.
        dir_op[0] = 3'd0; dir_bits[0] = 5'b01000; dir_exp[0] = 7'b0_001000; // SUB
        dir_op[1] = 3'd0; dir_bits[1] = 5'b01110; dir_exp[1] = 7'b1_000000; // no SRA-on-OR
        dir_op[2] = 3'd1; dir_bits[2] = 5'b00010; dir_exp[2] = 7'b1_000000; // BR f3=010
        dir_op[3] = 3'd3; dir_bits[3] = 5'b01101; dir_exp[3] = 7'b0_001101; // SRAI
        dir_op[4] = 3'd3; dir_bits[4] = 5'b01001; dir_exp[4] = 7'b1_000000; // SLLI f7b5
        dir_op[5] = 3'd6; dir_bits[5] = 5'b00000; dir_exp[5] = 7'b1_000000; // reserved ALUOp

        // Reset values
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ctrl", 32'(ALU_control), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_md_busy", 32'(md_busy), 32'd0);
        @(negedge CLK);
        RST_n = 1'b1;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            send(dir_op[i], dir_bits[i]);
            chk("dir_valid", 32'(out_valid), 32'd1);
            chk("dir_ctrl", 32'(ALU_control), 32'(dir_exp[i][5:0]));
            chk("dir_illegal", 32'(illegal), 32'(dir_exp[i][6]));
        end
        tick();
        chk("valid_one_cycle", 32'(out_valid), 32'd0);

        // Full sweep, one op per cycle except across MUL/DIV stalls
        for (int op = 0; op < 5; op++) begin
            for (int b = 0; b < 32; b++) begin
                exp = model(op[2:0], b[4:0]);
                ALUOp = op[2:0];
                instruction_bits = b[4:0];
                in_valid = 1'b1;
                tick();
                in_valid = 1'b0;
                chk("sweep_valid", 32'(out_valid), 32'd1);
                chk("sweep_ctrl", 32'(ALU_control), 32'(exp[5:0]));
                chk("sweep_illegal", 32'(illegal), 32'(exp[6]));
                if (exp[5:4] == 2'b10) begin
                    k = 0;
                    while (!in_ready && k < 100) begin
                        tick();
                        k++;
                    end
                    chk("sweep_stall", 32'(k), b[2] ? DIV_LAT - 1 : MUL_LAT - 1);
                end else begin
                    chk("sweep_ready", 32'(in_ready), 32'd1);
                end
            end
        end
        tick();

        // MUL op: stall length and busy window (or illegal without RV32M)
        send(3'd0, 5'b10000);
        chk("mul_ctrl", 32'(ALU_control), MEXT ? 32'h20 : 32'h00);
        chk("mul_illegal", 32'(illegal), MEXT ? 32'd0 : 32'd1);
        low_cnt = 0;
        busy_cnt = 0;
        vld_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (!in_ready) low_cnt++;
            if (md_busy) busy_cnt++;
            if (out_valid) vld_cnt++;
            tick();
        end
        chk("mul_ready_low", 32'(low_cnt), MEXT ? 32'd2 : 32'd0);
        chk("mul_busy", 32'(busy_cnt), MEXT ? 32'd2 : 32'd0);
        chk("mul_valid_pulses", 32'(vld_cnt), 32'd1);

`ifdef ALU_CTRL_MEXT_EN
        // DIV with the following op held valid through the stall
        send(3'd0, 5'b10100);
        chk("div_ctrl", 32'(ALU_control), 32'h24);
        ALUOp = 3'd1;
        instruction_bits = 5'b00001;
        in_valid = 1'b1;
        k = 0;
        low_cnt = 0;
        vld_cnt = 0;
        while (vld_cnt == 0 && k < 100) begin
            if (!in_ready) low_cnt++;
            tick();
            k++;
            if (out_valid) vld_cnt++;
        end
        in_valid = 1'b0;
        chk("div_ready_low", 32'(low_cnt), 32'd32);
        chk("div_next_cycle", 32'(k), 32'd33);
        chk("div_next_ctrl", 32'(ALU_control), 32'h11);
        tick();
        chk("div_no_dup", 32'(out_valid), 32'd0);

        // Flush on cycle 5 of a DIV stall
        send(3'd0, 5'b10101);
        for (int c = 0; c < 4; c++) tick();
        chk("pre_flush_busy", 32'(md_busy), 32'd1);
        flush = 1'b1;
        ALUOp = 3'd3;
        instruction_bits = 5'b00100;
        in_valid = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_busy", 32'(md_busy), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        chk("flush_valid", 32'(out_valid), 32'd0);
        tick();
        chk("flush_not_queued", 32'(out_valid), 32'd0);
        send(3'd3, 5'b00100);
        chk("post_flush_ctrl", 32'(ALU_control), 32'h04);
`else
        // Flush kills a same-cycle transfer
        flush = 1'b1;
        ALUOp = 3'd3;
        instruction_bits = 5'b00100;
        in_valid = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        send(3'd3, 5'b00100);
        chk("post_flush_ctrl", 32'(ALU_control), 32'h04);
`endif

        // Async reset right after a DIV is accepted
        send(3'd0, 5'b10110);
        chk("prereset_valid", 32'(out_valid), 32'd1);
        #1;
        RST_n = 1'b0;
        #1;
        chk("areset_valid", 32'(out_valid), 32'd0);
        chk("areset_ctrl", 32'(ALU_control), 32'd0);
        chk("areset_illegal", 32'(illegal), 32'd0);
        chk("areset_busy", 32'(md_busy), 32'd0);
        chk("areset_ready", 32'(in_ready), 32'd1);
        @(negedge CLK);
        RST_n = 1'b1;
        send(3'd0, 5'b00111);
        chk("post_reset_ctrl", 32'(ALU_control), 32'h07);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
